updown_counter_mod: RTL and testbench

//   Parametrised up/down counter with programmable modulus, synchronous load/clear,

---
 rtl/updown_counter_mod.sv | 95 +++++++++
 tb/tb_updown_counter_mod.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, sync clear/load, wrap or saturate mode.
// Latency: dout, wrap and sat update 1 clk after inputs are sampled; at_max/at_min decode the registered count.
// Backpressure: none; a new command is accepted on every rising clk edge.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   clr, load       synchronous clear to RST_VAL / load of load_val (clamped to MAX_VAL)
//   load_val        value for load
//   en, up          count enable and direction (1 = increment)
//   dout            current count, range 0..MAX_VAL
//   at_max, at_min  dout at top / bottom of range
//   wrap, sat       one-cycle pulses: last update wrapped / last enabled count was blocked

module updown_counter_mod #(
    parameter int             WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit             SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] dout,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             sat
);

    logic [WIDTH-1:0] dout_d, dout_q;
    logic             wrap_d, wrap_q;
    logic             sat_d,  sat_q;

    // Range ends are compared explicitly against MAX_VAL and zero so that
    // non-power-of-2 moduli never fall through to natural WIDTH-bit overflow.
    always_comb begin
        dout_d = dout_q;
        wrap_d = 1'b0;
        sat_d  = 1'b0;
        if (clr) begin
            dout_d = RST_VAL;
        end else if (load) begin
            // Out-of-range values clamp to the top of range rather than truncate.
            dout_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up) begin
                if (dout_q == MAX_VAL) begin
                    if (SATURATE) begin
                        sat_d = 1'b1;
                    end else begin
                        dout_d = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    dout_d = dout_q + WIDTH'(1);
                end
            end else begin
                if (dout_q == '0) begin
                    if (SATURATE) begin
                        sat_d = 1'b1;
                    end else begin
                        dout_d = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    dout_d = dout_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= RST_VAL;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign dout   = dout_q;
    assign wrap   = wrap_q;
    assign sat    = sat_q;
    // Decoded from the register only, so these never glitch within a cycle.
    assign at_max = (dout_q == MAX_VAL);
    assign at_min = (dout_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: one wrap-mode and one saturate-mode instance
// (WIDTH=4, MAX_VAL=9) driven from shared inputs, checked against hand-computed values.

module tb_updown_counter_mod;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up;

    logic [3:0] w_dout, s_dout;
    logic       w_at_max, w_at_min, w_wrap, w_sat;
    logic       s_at_max, s_at_min, s_wrap, s_sat;

    int errors = 0;
    int checks = 0;

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd0), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
        .dout(w_dout), .at_max(w_at_max), .at_min(w_at_min), .wrap(w_wrap), .sat(w_sat)
    );

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd3), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
        .dout(s_dout), .at_max(s_at_max), .at_min(s_at_min), .wrap(s_wrap), .sat(s_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_s [5];
        int exp_w [5];
        exp_s = '{8, 9, 9, 9, 9};
        exp_w = '{8, 9, 0, 1, 2};

        rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; up = 1'b0;

        // Reset state, no clock edge yet.
        #2;
        chk("rst_w_dout",   w_dout,   0);
        chk("rst_w_at_min", w_at_min, 1);
        chk("rst_w_at_max", w_at_max, 0);
        chk("rst_w_wrap",   w_wrap,   0);
        chk("rst_s_dout",   s_dout,   3);
        chk("rst_s_at_min", s_at_min, 0);
        chk("rst_s_sat",    s_sat,    0);

        // Count up 12 clocks: 1..9,0,1,2 with wrap only at 0.
        @(negedge clk);
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("up_dout",   w_dout,   (i + 1) % 10);
            chk("up_wrap",   w_wrap,   (i == 9) ? 1 : 0);
            chk("up_at_max", w_at_max, (i == 8) ? 1 : 0);
        end

        // Clear to 0, then count down: 9 (wrap), 8, 7.
        clr = 1'b1; en = 1'b0;
        step();
        chk("clr_w_dout",   w_dout,   0);
        chk("clr_w_at_min", w_at_min, 1);
        chk("clr_s_dout",   s_dout,   3);
        clr = 1'b0; en = 1'b1; up = 1'b0;
        step();
        chk("dn_dout_9",   w_dout,   9);
        chk("dn_wrap_9",   w_wrap,   1);
        chk("dn_at_max_9", w_at_max, 1);
        step();
        chk("dn_dout_8",   w_dout,   8);
        chk("dn_wrap_8",   w_wrap,   0);
        chk("dn_at_max_8", w_at_max, 0);
        step();
        chk("dn_dout_7",   w_dout,   7);

        // Load 7 together with en: load wins.
        load = 1'b1; load_val = 4'd7; up = 1'b1;
        step();
        chk("ld_en_w_dout", w_dout, 7);
        chk("ld_en_s_dout", s_dout, 7);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sat_dout",  s_dout, exp_s[i]);
            chk("sat_pulse", s_sat,  (i >= 2) ? 1 : 0);
            chk("sat_nowrap", s_wrap, 0);
            chk("wrapinst_dout", w_dout, exp_w[i]);
        end

        // Out-of-range load clamps to MAX_VAL; sat pulse drops.
        en = 1'b0; load = 1'b1; load_val = 4'hF;
        step();
        chk("clamp_w_dout", w_dout,   9);
        chk("clamp_s_dout", s_dout,   9);
        chk("clamp_at_max", w_at_max, 1);
        chk("clamp_s_sat",  s_sat,    0);

        // Load with clr: clr wins.
        clr = 1'b1; load_val = 4'd4;
        step();
        chk("clr_ld_w_dout", w_dout, 0);
        chk("clr_ld_s_dout", s_dout, 3);

        // Load with en: load wins.
        clr = 1'b0; en = 1'b1; up = 1'b0;
        step();
        chk("ld_en2_w_dout", w_dout, 4);
        chk("ld_en2_s_dout", s_dout, 4);

        // en=0 with up toggling: everything holds.
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            up = i[0];
            step();
            chk("hold_dout", w_dout, 4);
            chk("hold_sdout", s_dout, 4);
            chk("hold_wrap", w_wrap, 0);
            chk("hold_sat",  s_sat,  0);
        end

        // Decrement at 0: wrap instance goes to 9, saturate instance holds with sat.
        load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        chk("min_w_dout", w_dout, 9);
        chk("min_w_wrap", w_wrap, 1);
        chk("min_s_dout", s_dout, 0);
        chk("min_s_sat",  s_sat,  1);
        chk("min_s_wrap", s_wrap, 0);

        // Async reset mid-cycle while counting at 5.
        load = 1'b1; load_val = 4'd3; up = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        chk("pre_rst_dout", w_dout, 5);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_w_dout", w_dout, 0);
        chk("arst_s_dout", s_dout, 3);
        chk("arst_w_wrap", w_wrap, 0);
        chk("arst_s_sat",  s_sat,  0);
        rst = 1'b0;
        step();
        chk("resume_w_dout", w_dout, 1);
        chk("resume_s_dout", s_dout, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
